// File: rtl/collision_counter.sv
// Per-frame sprite collision detector: registers a hit flag and counts each distinct
// contact once (rising edge of contact), saturating at all-ones.
module collision_counter #(
    parameter int OBST_LANE   = 1,
    parameter int COUNT_WIDTH = 32,
    parameter int POS_WIDTH   = 12,
    parameter int VTHRESH     = 40,
    parameter int HTHRESH     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [POS_WIDTH-1:0]     player_hoffset,
    input  logic [POS_WIDTH-1:0]     player_voffset,
    input  logic [1:0]               player_lane,
    input  logic [POS_WIDTH-1:0]     obst_hoffset,
    input  logic [POS_WIDTH-1:0]     obst_voffset,
    input  logic [2*OBST_LANE-1:0]   obst_lane,
    output logic                     hit,
    output logic [COUNT_WIDTH-1:0]   count
);

    // One extra bit so the offset difference can never wrap.
    localparam int DW = POS_WIDTH + 1;
    localparam logic [DW-1:0]          V_LIM     = DW'(VTHRESH);
    localparam logic [DW-1:0]          H_LIM     = DW'(HTHRESH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic [DW-1:0] dv;
    logic [DW-1:0] dh;
    logic [DW-1:0] dv_abs;
    logic [DW-1:0] dh_abs;
    logic          lane_match;
    logic          v_ok;
    logic          h_ok;
    logic          contact;

    assign dv = {obst_voffset[POS_WIDTH-1], obst_voffset}
              - {player_voffset[POS_WIDTH-1], player_voffset};
    assign dh = {obst_hoffset[POS_WIDTH-1], obst_hoffset}
              - {player_hoffset[POS_WIDTH-1], player_hoffset};

    assign dv_abs = dv[DW-1] ? -dv : dv;
    assign dh_abs = dh[DW-1] ? -dh : dh;

    assign v_ok = (dv_abs <= V_LIM);
    assign h_ok = (HTHRESH == 0) || (dh_abs <= H_LIM);

    // Lane 3 is invalid: an equal obstacle entry can only match a valid player lane.
    always_comb begin
        lane_match = 1'b0;
        for (int i = 0; i < OBST_LANE; i++) begin
            if (player_lane != 2'd3 && obst_lane[2*i +: 2] == player_lane) begin
                lane_match = 1'b1;
            end
        end
    end

    assign contact = lane_match & v_ok & h_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit   <= 1'b0;
            count <= '0;
        end else begin
            hit <= contact;
            if (contact && !hit && count != COUNT_MAX) begin
                count <= count + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_collision_counter.sv
// Bench for collision_counter: two instances (default single-lane and a two-lane,
// 3-bit-counter, horizontal-check variant) checked against a behavioural model.
module tb_collision_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus kept as plain integers; the DUT sees the low bits.
    int a_pl = 0, a_ol = 0, a_pv = 0, a_ov = 0, a_ph = 0, a_oh = 0;
    int b_pl = 2, b_ol0 = 2, b_ol1 = 1, b_pv = 0, b_ov = 0, b_ph = 0, b_oh = 0;

    logic [11:0] a_player_hoffset, a_player_voffset, a_obst_hoffset, a_obst_voffset;
    logic [1:0]  a_player_lane, a_obst_lane;
    logic        a_hit;
    logic [31:0] a_count;

    logic [11:0] b_player_hoffset, b_player_voffset, b_obst_hoffset, b_obst_voffset;
    logic [1:0]  b_player_lane;
    logic [3:0]  b_obst_lane;
    logic        b_hit;
    logic [2:0]  b_count;

    assign a_player_hoffset = a_ph[11:0];
    assign a_player_voffset = a_pv[11:0];
    assign a_obst_hoffset   = a_oh[11:0];
    assign a_obst_voffset   = a_ov[11:0];
    assign a_player_lane    = a_pl[1:0];
    assign a_obst_lane      = a_ol[1:0];

    assign b_player_hoffset = b_ph[11:0];
    assign b_player_voffset = b_pv[11:0];
    assign b_obst_hoffset   = b_oh[11:0];
    assign b_obst_voffset   = b_ov[11:0];
    assign b_player_lane    = b_pl[1:0];
    assign b_obst_lane      = {b_ol1[1:0], b_ol0[1:0]};

    collision_counter dut_a (
        .clk(clk), .rst_n(rst_n),
        .player_hoffset(a_player_hoffset), .player_voffset(a_player_voffset),
        .player_lane(a_player_lane),
        .obst_hoffset(a_obst_hoffset), .obst_voffset(a_obst_voffset),
        .obst_lane(a_obst_lane),
        .hit(a_hit), .count(a_count)
    );

    collision_counter #(.OBST_LANE(2), .COUNT_WIDTH(3), .HTHRESH(10)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .player_hoffset(b_player_hoffset), .player_voffset(b_player_voffset),
        .player_lane(b_player_lane),
        .obst_hoffset(b_obst_hoffset), .obst_voffset(b_obst_voffset),
        .obst_lane(b_obst_lane),
        .hit(b_hit), .count(b_count)
    );

    // ---------------- model ----------------
    function automatic bit model_contact(input int pl, input int ol0, input int ol1,
                                         input int nl, input int pv, input int ov,
                                         input int ph, input int oh,
                                         input int vt, input int ht);
        bit lane;
        int adv;
        int adh;
        lane = 0;
        if (pl != 3) begin
            if (ol0 == pl && ol0 != 3) lane = 1;
            if (nl > 1 && ol1 == pl && ol1 != 3) lane = 1;
        end
        adv = (ov - pv < 0) ? pv - ov : ov - pv;
        adh = (oh - ph < 0) ? ph - oh : oh - ph;
        return lane && (adv <= vt) && (ht == 0 || adh <= ht);
    endfunction

    bit     ma_hit = 0, mb_hit = 0;
    longint ma_cnt = 0, mb_cnt = 0;
    localparam longint MA_MAX = 64'h0000_0000_FFFF_FFFF;
    localparam longint MB_MAX = 7;

    always @(posedge clk or negedge rst_n) begin
        bit ca, cb;
        if (!rst_n) begin
            ma_hit = 0; ma_cnt = 0;
            mb_hit = 0; mb_cnt = 0;
        end else begin
            ca = model_contact(a_pl, a_ol, 0, 1, a_pv, a_ov, a_ph, a_oh, 40, 0);
            cb = model_contact(b_pl, b_ol0, b_ol1, 2, b_pv, b_ov, b_ph, b_oh, 40, 10);
            if (ca && !ma_hit && ma_cnt < MA_MAX) ma_cnt++;
            if (cb && !mb_hit && mb_cnt < MB_MAX) mb_cnt++;
            ma_hit = ca;
            mb_hit = cb;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_a_hit", a_hit, ma_hit);
        check("model_a_count", a_count, ma_cnt);
        check("model_b_hit", b_hit, mb_hit);
        check("model_b_count", b_count, mb_cnt);
    end

    // ---------------- drivers ----------------
    task automatic frame_a(input int pl, input int ol, input int pv, input int ov);
        @(negedge clk);
        a_pl = pl; a_ol = ol; a_pv = pv; a_ov = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_b(input int pl, input int ph, input int oh, input int ov);
        @(negedge clk);
        b_pl = pl; b_ph = ph; b_oh = oh; b_ov = ov; b_pv = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with contact present on both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_hit", a_hit, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_a_hit", a_hit, 1);
        check("rel_a_count", a_count, 1);
        check("rel_b_count", b_count, 1);

        frame_b(2, 0, 0, 500);
        frame_a(0, 0, 0, 500);
        check("off_a_hit", a_hit, 0);

        // Single pass in lane 0.
        for (int ov = -140; ov <= 220; ov += 32) begin
            frame_a(0, 0, 50, ov);
            check("sweep_hit", a_hit, (ov == 20 || ov == 52 || ov == 84) ? 1 : 0);
        end
        check("sweep_count", a_count, 2);

        // Same pass, player in the other lane.
        for (int ov = -140; ov <= 220; ov += 32) begin
            frame_a(1, 0, 50, ov);
            check("miss_hit", a_hit, 0);
        end
        check("miss_count", a_count, 2);

        // Re-entry: 3 on, 1 off, 2 on.
        repeat (3) frame_a(0, 0, 0, 0);
        frame_a(0, 0, 0, 300);
        repeat (2) frame_a(0, 0, 0, 0);
        frame_a(0, 0, 0, 300);
        check("reentry_count", a_count, 4);

        // Vertical threshold boundaries.
        frame_a(0, 0, 0, 40);
        check("dv_p40", a_hit, 1);
        frame_a(0, 0, 0, 41);
        check("dv_p41", a_hit, 0);
        frame_a(0, 0, 0, -40);
        check("dv_m40", a_hit, 1);
        frame_a(0, 0, 0, -41);
        check("dv_m41", a_hit, 0);
        check("boundary_count", a_count, 6);

        // Extreme offsets must not wrap into a small distance.
        frame_a(0, 0, 2047, -2048);
        check("nowrap_1", a_hit, 0);
        frame_a(0, 0, -2048, 2047);
        check("nowrap_2", a_hit, 0);
        frame_a(3, 3, 0, 0);
        check("lane3", a_hit, 0);
        check("edge_count", a_count, 6);
        frame_a(0, 0, 0, 500);

        // Two-lane object occupying lanes 1 and 2.
        frame_b(2, 0, 0, 0);
        check("ml_lane2_hit", b_hit, 1);
        frame_b(2, 0, 0, 500);
        frame_b(0, 0, 0, 0);
        check("ml_lane0_hit", b_hit, 0);
        check("ml_count", b_count, 2);

        // Horizontal threshold boundaries.
        frame_b(2, 0, 10, 0);
        check("dh_p10", b_hit, 1);
        frame_b(2, 0, 11, 0);
        check("dh_p11", b_hit, 0);
        frame_b(2, 0, -10, 0);
        check("dh_m10", b_hit, 1);
        frame_b(2, 0, -11, 0);
        check("dh_m11", b_hit, 0);
        check("dh_count", b_count, 4);

        // Saturation of the 3-bit counter.
        for (int i = 0; i < 9; i++) begin
            frame_b(1, 0, 0, 0);
            frame_b(1, 0, 0, 500);
        end
        check("sat_count", b_count, 7);

        // Asynchronous reset mid-contact, then recount on release.
        frame_a(0, 0, 0, 0);
        frame_b(2, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_a_hit", a_hit, 0);
        check("async_a_count", a_count, 0);
        check("async_b_count", b_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerel_a_hit", a_hit, 1);
        check("rerel_a_count", a_count, 1);
        check("rerel_b_count", b_count, 1);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
